ghost_path_sequencer: RTL and testbench

Parametrised ghost-path player serving N ghosts from one shared synchronous path ROM. Each ghost walks its own segment of the ROM (base address plus last index), in loop or ping-pong mode, with a per-ghost freeze. Reads are time-multiplexed over a single ROM port. All ghost positions are committed to the outputs together, so the game FSM and renderer never see a half-updated set. It sits between the game-tick generator and the collision/draw logic, and replaces the per-ghost path counters.

---
 rtl/ghost_path_sequencer.sv | 149 ++++++++++++++
 tb/tb_ghost_path_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ghost_path_sequencer.sv
// ghost_path_sequencer: N ghosts walking segments of one shared path ROM, positions committed atomically
module ghost_path_sequencer #(
    parameter int N_GHOSTS = 3,
    parameter int ADDR_W = 8,
    parameter int X_W = 5,
    parameter int Y_W = 4,
    parameter logic [N_GHOSTS*ADDR_W-1:0] PATH_BASE = {8'd143, 8'd64, 8'd0},
    parameter logic [N_GHOSTS*ADDR_W-1:0] PATH_LAST = {8'd50, 8'd78, 8'd63}
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    step,
    input  logic                    restart,
    input  logic [N_GHOSTS-1:0]     freeze,
    input  logic [N_GHOSTS-1:0]     mode,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [10:0]             rom_q,
    output logic [N_GHOSTS*X_W-1:0] pos_x,
    output logic [N_GHOSTS*Y_W-1:0] pos_y,
    output logic                    pos_valid,
    output logic                    update,
    output logic                    busy,
    output logic                    overrun
);
    localparam int K_W = (N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_GHOSTS - 1);

    typedef enum logic [1:0] {LOAD, IDLE, FETCH, CAPTURE} state_t;

    state_t            state;
    logic              boot;
    logic              pending;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    kn;
    logic [ADDR_W-1:0] idx [N_GHOSTS];
    logic [ADDR_W-1:0] nxt_idx [N_GHOSTS];
    logic [N_GHOSTS-1:0] dir;
    logic [N_GHOSTS-1:0] nxt_dir;
    logic [X_W-1:0]    sh_x [N_GHOSTS];
    logic [Y_W-1:0]    sh_y [N_GHOSTS];
    logic              rom_unused;

    assign kn = k + 1'b1;
    assign rom_unused = ^rom_q[1:0];

    function automatic logic [ADDR_W-1:0] base_of(input logic [K_W-1:0] i);
        return PATH_BASE[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] last_of(input int g);
        return PATH_LAST[g*ADDR_W +: ADDR_W];
    endfunction

    // index and direction each ghost would take if a step were accepted now
    always_comb begin
        for (int g = 0; g < N_GHOSTS; g++) begin
            nxt_idx[g] = idx[g];
            nxt_dir[g] = dir[g];
            if (!freeze[g]) begin
                nxt_idx[g] = (last_of(g) == '0) ? '0 :
                             !mode[g] ? ((idx[g] == last_of(g)) ? '0 : idx[g] + 1'b1) :
                             !dir[g]  ? ((idx[g] == last_of(g)) ? last_of(g) - 1'b1 : idx[g] + 1'b1) :
                                        ((idx[g] == '0) ? ADDR_W'(1) : idx[g] - 1'b1);
                nxt_dir[g] = (last_of(g) != '0) && mode[g] &&
                             (dir[g] ? (idx[g] != '0) : (idx[g] == last_of(g)));
            end
        end
    end

    // sequencer: advance, fetch each ghost in turn, then commit all positions on one edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            boot      <= 1'b1;
            pending   <= 1'b0;
            k         <= '0;
            rom_addr  <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            pos_valid <= 1'b0;
            update    <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            dir       <= '0;
            for (int g = 0; g < N_GHOSTS; g++) begin
                idx[g]  <= '0;
                sh_x[g] <= '0;
                sh_y[g] <= '0;
            end
        end else begin
            update <= 1'b0;
            if (restart || boot) begin
                boot    <= 1'b0;
                state   <= LOAD;
                busy    <= 1'b0;
                pending <= 1'b0;
                overrun <= 1'b0;
                dir     <= '0;
                for (int g = 0; g < N_GHOSTS; g++) idx[g] <= '0;
            end else begin
                if (step && state != IDLE) begin
                    overrun <= overrun | pending;
                    pending <= 1'b1;
                end
                case (state)
                    LOAD: begin
                        state    <= FETCH;
                        k        <= '0;
                        busy     <= 1'b1;
                        rom_addr <= base_of('0) + idx[0];
                    end
                    IDLE: begin
                        if (step || pending) begin
                            for (int g = 0; g < N_GHOSTS; g++) idx[g] <= nxt_idx[g];
                            dir      <= nxt_dir;
                            pending  <= step & pending;
                            state    <= FETCH;
                            k        <= '0;
                            busy     <= 1'b1;
                            rom_addr <= base_of('0) + nxt_idx[0];
                        end
                    end
                    FETCH: begin
                        if (k != '0) begin
                            sh_x[k - 1'b1] <= rom_q[10 -: X_W];
                            sh_y[k - 1'b1] <= rom_q[5 -: Y_W];
                        end
                        if (k == K_LAST) begin
                            state <= CAPTURE;
                        end else begin
                            k        <= kn;
                            rom_addr <= base_of(kn) + idx[kn];
                        end
                    end
                    default: begin
                        for (int g = 0; g < N_GHOSTS; g++) begin
                            pos_x[g*X_W +: X_W] <= (g == N_GHOSTS - 1) ? rom_q[10 -: X_W] : sh_x[g];
                            pos_y[g*Y_W +: Y_W] <= (g == N_GHOSTS - 1) ? rom_q[5 -: Y_W] : sh_y[g];
                        end
                        update    <= 1'b1;
                        pos_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ghost_path_sequencer.sv
// tb_ghost_path_sequencer: directed vector table plus hand-written corner sequences
module tb_ghost_path_sequencer;
    localparam logic [23:0] BASE = {8'd143, 8'd64, 8'd0};

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        step = 1'b0;
    logic        restart = 1'b0;
    logic [2:0]  freeze = '0;
    logic [2:0]  mode = '0;
    logic [7:0]  rom_addr;
    logic [10:0] rom_q = '0;
    logic [14:0] pos_x;
    logic [11:0] pos_y;
    logic        pos_valid, update, busy, overrun;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit         rst;
        logic [2:0] fr;
        logic [2:0] md;
        int         n;
        int         e0, e1, e2;
    } vec_t;

    ghost_path_sequencer dut (
        .clock(clock), .resetn(resetn), .step(step), .restart(restart),
        .freeze(freeze), .mode(mode), .rom_addr(rom_addr), .rom_q(rom_q),
        .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .update(update),
        .busy(busy), .overrun(overrun)
    );

    function automatic logic [10:0] rom_word(input logic [7:0] a);
        return {a[4:0], a[7:4], ~a[1:0]};
    endfunction

    always #5 clock = ~clock;

    // synchronous ROM with one cycle of read latency
    always @(posedge clock) rom_q <= rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int i0, input int i1, input int i2);
        logic [14:0] ex;
        logic [11:0] ey;
        logic [7:0]  a;
        int          id [3];
        id = '{i0, i1, i2};
        for (int g = 0; g < 3; g++) begin
            a = BASE[g*8 +: 8] + 8'(id[g]);
            ex[g*5 +: 5] = a[4:0];
            ey[g*4 +: 4] = a[7:4];
        end
        check({name, ".x"}, 32'(pos_x), 32'(ex));
        check({name, ".y"}, 32'(pos_y), 32'(ey));
    endtask

    task automatic wait_upd(input int budget, output int cyc);
        cyc = 0;
        while (update !== 1'b1 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic pulse(input logic s, input logic r);
        step = s;
        restart = r;
        @(negedge clock);
        step = 1'b0;
        restart = 1'b0;
    endtask

    task automatic do_step(input string name);
        int c;
        pulse(1'b1, 1'b0);
        wait_upd(12, c);
        check(name, c, 4);
    endtask

    task automatic quiet(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n += int'(update);
        end
        check(name, n, 0);
    endtask

    task automatic check_zero(input string name);
        check({name, ".rom_addr"}, 32'(rom_addr), 0);
        check({name, ".pos_x"}, 32'(pos_x), 0);
        check({name, ".pos_y"}, 32'(pos_y), 0);
        check({name, ".flags"}, 32'({pos_valid, update, busy, overrun}), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [11];
        int   c;
        vt[0]  = '{1'b1, 3'b000, 3'b000, 63, 63, 63, 12};
        vt[1]  = '{1'b0, 3'b000, 3'b000, 1, 0, 64, 13};
        vt[2]  = '{1'b1, 3'b000, 3'b010, 78, 14, 78, 27};
        vt[3]  = '{1'b0, 3'b000, 3'b010, 3, 17, 75, 30};
        vt[4]  = '{1'b0, 3'b010, 3'b010, 5, 22, 75, 35};
        vt[5]  = '{1'b0, 3'b000, 3'b010, 75, 33, 0, 8};
        vt[6]  = '{1'b0, 3'b000, 3'b010, 2, 35, 2, 10};
        vt[7]  = '{1'b0, 3'b000, 3'b111, 1, 36, 3, 11};
        vt[8]  = '{1'b1, 3'b000, 3'b111, 64, 62, 64, 36};
        vt[9]  = '{1'b0, 3'b000, 3'b000, 1, 63, 65, 37};
        vt[10] = '{1'b0, 3'b111, 3'b000, 2, 63, 65, 37};

        repeat (3) @(negedge clock);
        check_zero("reset");
        resetn = 1'b1;
        wait_upd(20, c);
        check("boot_update_latency", c, 6);
        check("boot_pos_valid", 32'(pos_valid), 1);
        check_pos("boot_pos", 0, 0, 0);

        for (int v = 0; v < 11; v++) begin
            freeze = vt[v].fr;
            mode = vt[v].md;
            if (vt[v].rst) begin
                pulse(1'b0, 1'b1);
                wait_upd(12, c);
                check($sformatf("vec%0d_restart_latency", v), c, 5);
                check_pos($sformatf("vec%0d_restart_pos", v), 0, 0, 0);
            end
            for (int s = 0; s < vt[v].n; s++) do_step($sformatf("vec%0d_step%0d", v, s));
            check_pos($sformatf("vec%0d", v), vt[v].e0, vt[v].e1, vt[v].e2);
        end

        freeze = '0;
        mode = '0;
        pulse(1'b1, 1'b0);
        for (int t = 1; t <= 5; t++) begin
            check($sformatf("timing_busy_t%0d", t), 32'(busy), 32'(t <= 4));
            check($sformatf("timing_update_t%0d", t), 32'(update), 32'(t == 5));
            check($sformatf("timing_addr_t%0d", t), 32'(rom_addr), t == 1 ? 0 : t == 2 ? 130 : 181);
            if (t < 5) @(negedge clock);
        end
        check_pos("timing_pos", 0, 66, 38);

        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("abort_overrun_set", 32'(overrun), 1);
        check("abort_busy", 32'(busy), 1);
        pulse(1'b1, 1'b1);
        check("abort_overrun_clr", 32'(overrun), 0);
        check("abort_busy_clr", 32'(busy), 0);
        wait_upd(12, c);
        check("abort_load_latency", c, 5);
        check_pos("abort_load_pos", 0, 0, 0);
        quiet("abort_no_pending");

        pulse(1'b1, 1'b0);
        @(negedge clock);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        wait_upd(12, c);
        check("pend_first_latency", c, 1);
        check("pend_overrun", 32'(overrun), 1);
        @(negedge clock);
        wait_upd(12, c);
        check("pend_second_latency", c, 4);
        check_pos("pend_pos", 2, 2, 2);
        quiet("pend_dropped");
        check("pend_overrun_sticky", 32'(overrun), 1);

        pulse(1'b1, 1'b0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clock);
        resetn = 1'b1;
        wait_upd(20, c);
        check("rereset_latency", c, 6);
        check_pos("rereset_pos", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
